num_char_conv: RTL and testbench
================================

# num_char_conv

Parametrised conversion unit for MIX opcode 5: NUM (F=0, character codes to binary) and CHAR (F=1, binary to character codes). Successor to the fixed-width NUM-only unit: byte width, byte count and word width are parametrised, CHAR is added, and overflow is reported. Sits beside the ALU and is started by the control sequencer. It handles magnitudes only; the sequencer preserves register signs.

## Interface
- BYTE_W, 6, bits per MIX byte
- NBYTES, 10, bytes in the rA:rX character field
- WORD_W, 30, magnitude width of the binary word
- ZERO_CODE, 30, character code of digit 0 (digit d maps to ZERO_CODE+d)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request; sampled only when idle
- mode  in  1  0 = NUM, 1 = CHAR; sampled with start
- chars_in  in  NBYTES*BYTE_W  NUM source; most significant byte in the top bits
- word_in  in  WORD_W  CHAR source magnitude
- num_out  out  WORD_W  NUM result
- char_out  out  NBYTES*BYTE_W  CHAR result
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse marking the first cycle results are valid
- overflow  out  1  result did not fit; valid with done

## Operation
- States: IDLE, NUM_RUN, CHAR_RUN. All state is cleared by reset.
- IDLE with start=1:
  - mode=0: latch chars_in into a shift register, clear the accumulator, go to NUM_RUN.
  - mode=1: latch word_in into a shift register, clear the BCD register (NBYTES 4-bit digits), go to CHAR_RUN.
  - Clear overflow.
- NUM_RUN, one byte per cycle, MSB first:
  - digit = byte mod 10, for any BYTE_W.
  - acc <= (acc*10 + digit) mod 2^WORD_W.
  - overflow is set sticky when the true sum is ≥ 2^WORD_W, which is equivalent to the true final value being ≥ 2^WORD_W.
  - Exactly NBYTES steps.
- CHAR_RUN, double-dabble, one bit per cycle, MSB first:
  - Add 3 to each BCD digit ≥ 5, then shift the BCD register left one bit and shift in the next word bit.
  - A 1 shifted out of the top digit sets overflow (value ≥ 10^NBYTES). High-order digits are lost.
  - Exactly WORD_W steps.
- Completion: the final step writes num_out (NUM) or char_out (CHAR, each byte = ZERO_CODE + BCD digit), pulses done and returns to IDLE.
  - The output of the other mode keeps its previous value.
  - Outputs hold until the next completion or reset.
- start while busy is ignored. mode and the data inputs are don't-care outside the start cycle.
- Reset values: num_out=0, char_out=0, busy=0, done=0, overflow=0, state IDLE.

## Timing
- Start accepted at edge E0. busy is high from E0 through E(L), low after E(L).
  - L = NBYTES for NUM (10 by default).
  - L = WORD_W for CHAR (30 by default).
- done and overflow are valid in the cycle after edge E(L). done is high for exactly one cycle.
- A new start may be accepted at edge E(L+1), i.e. in the done cycle, giving back-to-back operation.
- Reset asserted mid-operation: immediate return to IDLE with all outputs cleared. No done pulse is produced.

## Configuration
- NUM_CHAR_OVERFLOW_EN defined: overflow is detected and reported as above.
- Undefined: overflow is tied to 0 and no detection logic is built. Wrap and truncation behaviour of the results is unchanged.

## Test plan
- NUM example: bytes 0,0,31,32,39,37,57,47,30,30 → num_out=12977700, overflow=0, done 10 cycles after start.
- NUM overflow: all ten bytes 39 → num_out=336323583 (9999999999 mod 2^30), overflow=1.
- CHAR: word_in=12977699 → char_out bytes 30,30,31,32,39,37,37,36,39,39, overflow=0, done 30 cycles after start. word_in=0 → all bytes 30.
- Handshake: start pulsed in cycles 3 and 5 after a NUM start → single done at cycle 10; a start issued in the done cycle is accepted.
- Reset at cycle 15 of a CHAR run → busy=0, all outputs 0, no done pulse; the next NUM run is correct.
- Build without NUM_CHAR_OVERFLOW_EN, repeat the NUM overflow case → num_out=336323583, overflow=0.

Source files
------------

// File: rtl/num_char_conv.sv
// num_char_conv: MIX NUM (chars->binary) / CHAR (binary->chars) magnitude converter.
// Define NUM_CHAR_OVERFLOW_EN to build overflow detection; otherwise overflow is tied to 0.
module num_char_conv #(
  parameter int BYTE_W    = 6,
  parameter int NBYTES    = 10,
  parameter int WORD_W    = 30,
  parameter int ZERO_CODE = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [NBYTES*BYTE_W-1:0] chars_in,
  input  logic [WORD_W-1:0]        word_in,
  output logic [WORD_W-1:0]        num_out,
  output logic [NBYTES*BYTE_W-1:0] char_out,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);
  localparam int CW    = NBYTES * BYTE_W;
  localparam int BW    = NBYTES * 4;
  localparam int SW    = WORD_W + 4;
  localparam int CNT_W = $clog2((NBYTES > WORD_W ? NBYTES : WORD_W) + 1);
  typedef enum logic [1:0] {IDLE, NUM_RUN, CHAR_RUN} state_t;
  state_t r_state, w_next;
  logic [CW-1:0]     r_chr;
  logic [WORD_W-1:0] r_acc;
  logic [WORD_W-1:0] r_word;
  logic [BW-1:0]     r_bcd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;
  logic [3:0]        w_digit;
  logic [SW-1:0]     w_sum;
  logic [BW-1:0]     w_adj;
  logic [BW-1:0]     w_bcd_next;
  logic [CW-1:0]     w_chars;
  logic              w_start;
  logic              w_last;
  assign w_start = (r_state == IDLE) && start;
  assign w_last  = (r_state == NUM_RUN  && r_cnt == CNT_W'(NBYTES - 1)) ||
                   (r_state == CHAR_RUN && r_cnt == CNT_W'(WORD_W - 1));
  assign w_digit = 4'(r_chr[CW-1 -: BYTE_W] % BYTE_W'(10));
  assign w_sum   = {4'b0, r_acc} * SW'(10) + SW'(w_digit);
  // double-dabble: +3 on digits >= 5 before the shift
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NBYTES; i++)
      w_adj[i*4 +: 4] = (r_bcd[i*4 +: 4] >= 4'd5) ? r_bcd[i*4 +: 4] + 4'd3 : r_bcd[i*4 +: 4];
  end
  assign w_bcd_next = {w_adj[BW-2:0], r_word[WORD_W-1]};
  always_comb begin
    w_chars = '0;
    for (int i = 0; i < NBYTES; i++)
      w_chars[i*BYTE_W +: BYTE_W] = BYTE_W'(ZERO_CODE) + BYTE_W'(w_bcd_next[i*4 +: 4]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_start)     w_next = mode ? CHAR_RUN : NUM_RUN;
    else if (w_last) w_next = IDLE;
  end
  always_comb begin
    busy = r_state != IDLE;
    done = r_done;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chr    <= '0;
      r_acc    <= '0;
      r_word   <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      num_out  <= '0;
      char_out <= '0;
    end else begin
      r_done <= w_last;
      if (w_start) begin
        r_chr  <= chars_in;
        r_acc  <= '0;
        r_word <= word_in;
        r_bcd  <= '0;
        r_cnt  <= '0;
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_state == NUM_RUN) begin
          r_chr <= r_chr << BYTE_W;
          r_acc <= w_sum[WORD_W-1:0];
        end else begin
          r_word <= r_word << 1;
          r_bcd  <= w_bcd_next;
        end
      end
      if (w_last && r_state == NUM_RUN)  num_out  <= w_sum[WORD_W-1:0];
      if (w_last && r_state == CHAR_RUN) char_out <= w_chars;
    end
  end
`ifdef NUM_CHAR_OVERFLOW_EN
  logic r_ovf;
  always_ff @(posedge clk or posedge reset)
    if (reset)        r_ovf <= 1'b0;
    else if (w_start) r_ovf <= 1'b0;
    else if ((r_state == NUM_RUN && |w_sum[SW-1:WORD_W]) || (r_state == CHAR_RUN && w_adj[BW-1]))
      r_ovf <= 1'b1;
  assign overflow = r_ovf;
`else
  logic w_unused;
  assign w_unused = |{w_sum[SW-1:WORD_W], w_adj[BW-1]};
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_num_char_conv.sv
// tb_num_char_conv: table vectors, hand sequences and random ops against a decimal reference model.
module tb_num_char_conv;
`ifdef NUM_CHAR_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic        clk = 0;
  logic        reset, start, mode;
  logic [59:0] chars_in;
  logic [29:0] word_in;
  logic [29:0] num_out;
  logic [59:0] char_out;
  logic        busy, done, overflow;
  int n_checks = 0;
  int n_err = 0;
  logic [29:0] prev_num;
  logic [59:0] prev_char;

  num_char_conv dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .chars_in(chars_in),
    .word_in(word_in), .num_out(num_out), .char_out(char_out), .busy(busy),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m;
    logic [59:0] c;
    logic [29:0] w;
    logic [29:0] en;
    logic [59:0] ec;
    bit          eo;
    string       nm;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [59:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
    return {6'(a0), 6'(a1), 6'(a2), 6'(a3), 6'(a4), 6'(a5), 6'(a6), 6'(a7), 6'(a8), 6'(a9)};
  endfunction

  function automatic void ref_model(input bit m, input logic [59:0] c, input logic [29:0] w,
                                    output logic [29:0] en, output logic [59:0] ec, output bit eo);
    longint v;
    en = prev_num;
    ec = prev_char;
    v = 0;
    if (!m) begin
      for (int i = 9; i >= 0; i--) v = v * 10 + longint'(c[i*6 +: 6]) % 10;
      en = 30'(v % (longint'(1) << 30));
      eo = v >= (longint'(1) << 30);
    end else begin
      v = longint'(w);
      for (int i = 0; i < 10; i++) begin
        ec[i*6 +: 6] = 6'(30 + v % 10);
        v = v / 10;
      end
      eo = v != 0;
    end
  endfunction

  // Call at a negedge; returns at the negedge where done is seen.
  task automatic do_op(input bit m, input logic [59:0] c, input logic [29:0] w, input bit spur,
                       input logic [29:0] en, input logic [59:0] ec, input bit eo, input string nm);
    int k;
    bit busy_ok;
    busy_ok = 1;
    mode = m; chars_in = c; word_in = w; start = 1;
    @(negedge clk);
    start = 0; mode = 1'($urandom); chars_in = {$urandom, $urandom}; word_in = 30'($urandom);
    if (!busy) busy_ok = 0;
    k = 1;
    while (k <= 100) begin
      @(negedge clk);
      start = spur && (k == 3 || k == 5);
      if (done) break;
      if (!busy) busy_ok = 0;
      k++;
    end
    start = 0;
    chk({nm, "_latency"}, 64'(k), m ? 64'd30 : 64'd10);
    chk({nm, "_busy_run"}, 64'(busy_ok), 64'd1);
    chk({nm, "_busy_end"}, 64'(busy), 64'd0);
    chk({nm, "_num"}, 64'(num_out), 64'(en));
    chk({nm, "_char"}, 64'(char_out), 64'(ec));
    chk({nm, "_ovf"}, 64'(overflow), 64'(eo & OVF_EN));
  endtask

  task automatic run_model(input bit m, input logic [59:0] c, input logic [29:0] w, input bit spur, input string nm);
    logic [29:0] en;
    logic [59:0] ec;
    bit eo;
    ref_model(m, c, w, en, ec, eo);
    do_op(m, c, w, spur, en, ec, eo, nm);
    prev_num = en;
    prev_char = ec;
  endtask

  initial begin
    bit ok;
    tbl[0] = '{0, pk(0,0,31,32,39,37,57,47,30,30), 0, 30'd12977700, 0, 0, "num_ex"};
    tbl[1] = '{0, pk(39,39,39,39,39,39,39,39,39,39), 0, 30'd336323583, 0, 1, "num_ovf"};
    tbl[2] = '{1, 0, 30'd12977699, 0, pk(30,30,31,32,39,37,37,36,39,39), 0, "char_ex"};
    tbl[3] = '{1, 0, 30'd0, 0, pk(30,30,30,30,30,30,30,30,30,30), 0, "char_zero"};
    tbl[4] = '{1, 0, 30'h3FFFFFFF, 0, pk(31,30,37,33,37,34,31,38,32,33), 0, "char_max"};
    tbl[5] = '{0, pk(31,30,37,33,37,34,31,38,32,34), 0, 30'd0, 0, 1, "num_2p30"};
    tbl[6] = '{0, pk(31,30,37,33,37,34,31,38,32,33), 0, 30'h3FFFFFFF, 0, 0, "num_2p30m1"};
    tbl[7] = '{0, pk(63,63,63,63,63,63,63,63,63,63), 0, 30'd112107861, 0, 1, "num_mod63"};
    reset = 1; start = 0; mode = 0; chars_in = '0; word_in = '0;
    prev_num = '0; prev_char = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({num_out, char_out, busy, done, overflow}), 64'd0);
    chk("reset_char", 64'(char_out), 64'd0);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].m, tbl[i].c, tbl[i].w, 0, tbl[i].m ? prev_num : tbl[i].en,
            tbl[i].m ? tbl[i].ec : prev_char, tbl[i].eo, tbl[i].nm);
      if (tbl[i].m) prev_char = tbl[i].ec;
      else          prev_num = tbl[i].en;
      @(negedge clk);
      chk({tbl[i].nm, "_done_1cyc"}, 64'(done), 64'd0);
    end
    // starts during a run are ignored; one done only
    run_model(0, pk(0,0,31,32,39,37,57,47,30,30), 0, 1, "spur");
    ok = 1;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) ok = 0;
    end
    chk("spur_single_done", 64'(ok), 64'd1);
    // back-to-back: second start lands in the done cycle
    run_model(1, 0, 30'd987654321, 0, "b2b_a");
    run_model(0, pk(33,34,35,36,37,38,39,30,31,32), 0, 0, "b2b_b");
    run_model(1, 0, 30'd5, 0, "b2b_c");
    // reset during CHAR run
    @(negedge clk);
    mode = 1; word_in = 30'd12345; start = 1;
    @(negedge clk);
    start = 0;
    repeat (14) @(negedge clk);
    reset = 1;
    #1;
    chk("midreset_outputs", 64'({num_out, busy, done, overflow}), 64'd0);
    chk("midreset_char", 64'(char_out), 64'd0);
    @(negedge clk);
    reset = 0;
    prev_num = '0; prev_char = '0;
    ok = 1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ok = 0;
    end
    chk("midreset_no_done", 64'(ok), 64'd1);
    run_model(0, pk(0,0,31,32,39,37,57,47,30,30), 0, 0, "post_reset");
    for (int n = 0; n < 40; n++) begin
      logic [59:0] c;
      for (int b = 0; b < 10; b++) c[b*6 +: 6] = 6'($urandom_range(0, 63));
      run_model(1'($urandom), c, 30'($urandom), 0, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
